// File: rtl/pls2tgl_hs.sv
`default_nettype none
// ============================================================================
// Module   : pls2tgl_hs
// Purpose  : Multi-channel pulse-to-toggle encoder for the source side of a
//            CDC pulse synchronizer. Each channel turns single-cycle pulses
//            into transitions on tgl_o. In handshake mode a new transition
//            waits until the returned ack toggle matches, and pulses that
//            arrive meanwhile are counted (saturating) instead of lost.
// Ports    : clk        - source clock
//            rst_n      - synchronous active-low reset
//            pulse_i    - per-channel event (one event per high cycle)
//            ack_tgl_i  - per-channel ack toggle, already in clk domain
//            ovf_clr_i  - per-channel clear of the sticky overflow flag
//            tgl_o      - per-channel registered toggle output
//            busy_o     - transition outstanding or pulses pending
//            pending_o  - per-channel pending count, [i*CNT_W +: CNT_W]
//            ovf_o      - sticky flag: a pulse was dropped
// Revision : 1.0 - initial release
// ============================================================================
module pls2tgl_hs #(
  parameter int N_CH   = 1,
  parameter int CNT_W  = 4,
  parameter bit ACK_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         pulse_i,
  input  logic [N_CH-1:0]         ack_tgl_i,
  input  logic [N_CH-1:0]         ovf_clr_i,
  output logic [N_CH-1:0]         tgl_o,
  output logic [N_CH-1:0]         busy_o,
  output logic [N_CH*CNT_W-1:0]   pending_o,
  output logic [N_CH-1:0]         ovf_o
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    if (ACK_EN) begin : g_hs
      logic             tgl_q, tgl_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             ovf_q, ovf_d;
      logic             w_outstanding;
      logic             w_cnt_nz;
      logic             w_launch;
      logic             w_drop;

      // A transition is in flight until the ack toggle catches up with tgl.
      assign w_outstanding = tgl_q ^ ack_tgl_i[i];
      assign w_cnt_nz      = (cnt_q != '0);
      assign w_launch      = !w_outstanding && (pulse_i[i] || w_cnt_nz);

      always_comb begin
        cnt_d  = cnt_q;
        w_drop = 1'b0;
        if (pulse_i[i] && !w_launch) begin
          if (cnt_q == c_CNT_MAX) begin
            w_drop = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!pulse_i[i] && w_launch) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        // With both pulse and launch the count is unchanged: either the
        // pulse passes straight through, or it replaces the queued one
        // that just launched.
      end

      assign tgl_d = tgl_q ^ w_launch;
      // A drop in the same cycle as a clear keeps the flag set.
      assign ovf_d = w_drop | (ovf_q & ~ovf_clr_i[i]);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tgl_q <= 1'b0;
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          tgl_q <= tgl_d;
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
        end
      end

      assign tgl_o[i]                    = tgl_q;
      assign busy_o[i]                   = w_outstanding | w_cnt_nz;
      assign pending_o[i*CNT_W +: CNT_W] = cnt_q;
      assign ovf_o[i]                    = ovf_q;
    end else begin : g_plain
      logic tgl_q, tgl_d;
      // Ack and overflow clear have no meaning without flow control.
      logic w_unused_plain;

      assign tgl_d          = tgl_q ^ pulse_i[i];
      assign w_unused_plain = ack_tgl_i[i] ^ ovf_clr_i[i];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tgl_q <= 1'b0;
        end else begin
          tgl_q <= tgl_d;
        end
      end

      assign tgl_o[i]                    = tgl_q;
      assign busy_o[i]                   = 1'b0;
      assign pending_o[i*CNT_W +: CNT_W] = '0;
      assign ovf_o[i]                    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pls2tgl_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pls2tgl_hs
// Purpose  : Self-checking bench for pls2tgl_hs. Three instances share one
//            clock: A (handshake, CNT_W=4), B (handshake, CNT_W=2) and
//            C (plain mode, 4 channels). A reference model advances every
//            cycle and pushes expected outputs to a scoreboard queue that is
//            drained after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pls2tgl_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pa, acka, clra;
  logic pb, ackb, clrb;
  logic [3:0] pc, ackc, clrc;

  logic       tgla, busya, ovfa;
  logic [3:0] penda;
  logic       tglb, busyb, ovfb;
  logic [1:0] pendb;
  logic [3:0] tglc, busyc, ovfc;
  logic [15:0] pendc;

  pls2tgl_hs #(.N_CH(1), .CNT_W(4), .ACK_EN(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pulse_i(pa), .ack_tgl_i(acka), .ovf_clr_i(clra),
    .tgl_o(tgla), .busy_o(busya), .pending_o(penda), .ovf_o(ovfa));

  pls2tgl_hs #(.N_CH(1), .CNT_W(2), .ACK_EN(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pulse_i(pb), .ack_tgl_i(ackb), .ovf_clr_i(clrb),
    .tgl_o(tglb), .busy_o(busyb), .pending_o(pendb), .ovf_o(ovfb));

  pls2tgl_hs #(.N_CH(4), .CNT_W(4), .ACK_EN(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .pulse_i(pc), .ack_tgl_i(ackc), .ovf_clr_i(clrc),
    .tgl_o(tglc), .busy_o(busyc), .pending_o(pendc), .ovf_o(ovfc));

  typedef struct {
    int          id;
    logic [3:0]  tgl;
    logic [15:0] pend;
    logic [3:0]  ovf;
  } exp_t;

  typedef struct {
    logic [3:0] pulse;
    logic [3:0] ack;
    logic [3:0] tgl;
  } vec_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state for the two handshake instances and plain C.
  bit       m_tgl[2];
  int       m_cnt[2];
  bit       m_ovf[2];
  bit [3:0] m_c;

  // Loop-back ack for A, and statistics on A's observed behaviour.
  bit   loop_en;
  int   loop_d;
  bit   hist[$];
  int   tcnt;
  int   a_tog[$];
  int   a_busy_n;
  int   a_peak;
  logic a_prev_tgl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already set by the caller.
  task automatic tick();
    bit   p[2], ak[2], cl[2];
    int   mx[2];
    bit   drop;
    exp_t e, got;

    hist.push_back(m_tgl[0]);
    if (hist.size() > 16) void'(hist.pop_front());
    if (loop_en) acka = (hist.size() > loop_d) ? hist[hist.size()-1-loop_d] : 1'b0;

    p[0] = pa;   p[1] = pb;
    ak[0] = acka; ak[1] = ackb;
    cl[0] = clra; cl[1] = clrb;
    mx[0] = 15;  mx[1] = 3;

    @(negedge clk);
    if (rst_n) begin
      chk("busy_a", busya, (m_tgl[0] != ak[0]) || (m_cnt[0] != 0));
      chk("busy_b", busyb, (m_tgl[1] != ak[1]) || (m_cnt[1] != 0));
      chk("busy_c", busyc, 0);
      if (busya) a_busy_n++;
    end

    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_tgl[i] = 1'b0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end
      m_c = 4'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        drop = 1'b0;
        if (m_tgl[i] == ak[i] && (p[i] || m_cnt[i] != 0)) begin
          m_tgl[i] = !m_tgl[i];
          if (!p[i]) m_cnt[i] = m_cnt[i] - 1;
        end else if (p[i]) begin
          if (m_cnt[i] == mx[i]) drop = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
        if (drop) m_ovf[i] = 1'b1;
        else if (cl[i]) m_ovf[i] = 1'b0;
      end
      m_c = m_c ^ pc;
    end

    for (int i = 0; i < 2; i++) begin
      e.id = i; e.tgl = {3'b0, m_tgl[i]}; e.pend = 16'(m_cnt[i]); e.ovf = {3'b0, m_ovf[i]};
      sb.push_back(e);
    end
    e.id = 2; e.tgl = m_c; e.pend = 16'h0; e.ovf = 4'h0;
    sb.push_back(e);

    @(posedge clk);
    #1;
    tcnt++;
    while (sb.size() > 0) begin
      got = sb.pop_front();
      case (got.id)
        0: begin
          chk("tgl_a", tgla, got.tgl[0]);
          chk("pend_a", penda, got.pend[3:0]);
          chk("ovf_a", ovfa, got.ovf[0]);
        end
        1: begin
          chk("tgl_b", tglb, got.tgl[0]);
          chk("pend_b", pendb, got.pend[1:0]);
          chk("ovf_b", ovfb, got.ovf[0]);
        end
        default: begin
          chk("tgl_c", tglc, got.tgl);
          chk("pend_c", pendc, got.pend);
          chk("ovf_c", ovfc, got.ovf);
        end
      endcase
    end

    if (tgla !== a_prev_tgl) a_tog.push_back(tcnt);
    a_prev_tgl = tgla;
    if (int'(penda) > a_peak) a_peak = int'(penda);
  endtask

  task automatic clear_stats();
    a_tog.delete();
    a_busy_n = 0;
    a_peak   = 0;
  endtask

  initial begin
    vec_t vecs[5];
    int   t0;
    bit   t;

    vecs[0] = '{pulse: 4'b1010, ack: 4'b0000, tgl: 4'b1010};
    vecs[1] = '{pulse: 4'b1111, ack: 4'b1111, tgl: 4'b0101};
    vecs[2] = '{pulse: 4'b0000, ack: 4'b0101, tgl: 4'b0101};
    vecs[3] = '{pulse: 4'b0001, ack: 4'b0000, tgl: 4'b0100};
    vecs[4] = '{pulse: 4'b1000, ack: 4'b1010, tgl: 4'b1100};

    rst_n = 1'b0;
    pa = 0; acka = 0; clra = 0;
    pb = 0; ackb = 0; clrb = 0;
    pc = 0; ackc = 0; clrc = 0;
    loop_en = 1'b0; loop_d = 3; tcnt = 0;
    a_prev_tgl = 1'b0;
    clear_stats();

    // Reset state (scoreboard expects all zero).
    tick();
    tick();
    rst_n = 1'b1;
    a_prev_tgl = tgla;
    hist.delete();

    // Isolated pulses with 3-cycle loop-back ack.
    loop_en = 1'b1; loop_d = 3;
    clear_stats(); t0 = tcnt;
    for (int c = 0; c < 30; c++) begin
      pa = (c == 5 || c == 20);
      tick();
    end
    pa = 0;
    chk("t1_ntog", a_tog.size(), 2);
    if (a_tog.size() >= 2) begin
      chk("t1_tog0_cyc", a_tog[0] - t0, 6);
      chk("t1_tog1_cyc", a_tog[1] - t0, 21);
    end
    chk("t1_busy_cycles", a_busy_n, 6);
    chk("t1_pend_peak", a_peak, 0);

    // Burst of 5 pulses, ack delay 4.
    loop_d = 4;
    clear_stats(); t0 = tcnt;
    for (int c = 0; c < 40; c++) begin
      pa = (c < 5);
      tick();
    end
    pa = 0;
    chk("t2_ntog", a_tog.size(), 5);
    chk("t2_pend_peak", a_peak, 4);
    chk("t2_pend_end", penda, 0);
    if (a_tog.size() == 5) begin
      chk("t2_first_cyc", a_tog[0] - t0, 1);
      chk("t2_last_cyc", a_tog[4] - t0, 21);
    end

    // Overflow on B (max count 3), ack held at 0.
    ackb = 1'b0;
    pb = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("t3_pend_4p", pendb, 3);
    chk("t3_ovf_4p", ovfb, 0);
    chk("t3_tgl_4p", tglb, 1);
    tick();
    chk("t3_ovf_5p", ovfb, 1);
    chk("t3_pend_5p", pendb, 3);
    clrb = 1'b1;
    tick();
    chk("t3_ovf_set_wins", ovfb, 1);
    pb = 1'b0;
    tick();
    chk("t3_ovf_cleared", ovfb, 0);
    clrb = 1'b0;
    pb = 1'b1;
    tick();
    chk("t3_ovf_reset_again", ovfb, 1);
    pb = 1'b0; ackb = 1'b1;
    tick();
    chk("t3_pend_2", pendb, 2);
    chk("t3_tgl_0", tglb, 0);

    // Simultaneous launch on A with manual ack.
    loop_en = 1'b0;
    t = m_tgl[0];
    pa = 1'b1; acka = t;
    tick();
    chk("t4_a_tgl", tgla, !t);
    tick();
    chk("t4_b_pend", penda, 1);
    acka = !t;
    tick();
    chk("t4_c_tgl_once", tgla, t);
    chk("t4_c_pend", penda, 1);
    pa = 1'b0;
    tick();
    chk("t4_d_no_flip", tgla, t);
    chk("t4_d_pend", penda, 1);
    acka = t;
    tick();
    chk("t4_e_tgl", tgla, !t);
    chk("t4_e_pend", penda, 0);
    acka = !t;
    tick();

    // Plain mode on C, table driven.
    for (int i = 0; i < 5; i++) begin
      pc   = vecs[i].pulse;
      ackc = vecs[i].ack;
      clrc = ~vecs[i].ack;
      tick();
      chk("t5_plain_tgl", tglc, vecs[i].tgl);
    end
    pc = 0; clrc = 0;

    // Mid-operation reset with B holding pending=2 and ovf=1.
    chk("t6_pre_pend", pendb, 2);
    chk("t6_pre_ovf", ovfb, 1);
    rst_n = 1'b0;
    pb = 1'b1; ackb = 1'b0; acka = 1'b0;
    tick();
    chk("t6_rst_tgl", tglb, 0);
    chk("t6_rst_pend", pendb, 0);
    chk("t6_rst_ovf", ovfb, 0);
    rst_n = 1'b1;
    pb = 1'b0;
    hist.delete();
    tick();
    chk("t6_no_tgl_after", tglb, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pls2tgl_hs.md
# pls2tgl_hs

Multi-channel, parametrised pulse-to-toggle encoder with acknowledge flow control, for the source side of a clock-domain-crossing pulse synchronizer. Each channel converts single-cycle source pulses into toggle transitions on `tgl`. In handshake mode, a new transition is held back until the destination's returned acknowledge toggle matches, and pulses that arrive meanwhile are counted rather than lost. It sits in the source clock domain in front of the destination's toggle synchronizer and edge detector. The returning `ack_tgl` is synchronized into `clk` outside this block.

## Interface
Parameters:
- `N_CH`, 1: number of independent channels.
- `CNT_W`, 4: width of each channel's pending-pulse counter; saturates at 2^CNT_W-1.
- `ACK_EN`, 1: 1 selects handshake mode; 0 selects plain mode, where every pulse toggles immediately.

Ports (reset is synchronous, active-low `rst_n`, sampled on posedge `clk`; one clock domain):
- `clk`  in  1  source clock.
- `rst_n`  in  1  synchronous active-low reset.
- `pulse`  in  N_CH  per-channel single-cycle event; a multi-cycle high counts one event per cycle.
- `ack_tgl`  in  N_CH  destination acknowledge toggle, already synchronized to `clk`; ignored when ACK_EN=0.
- `ovf_clr`  in  N_CH  per-channel clear for `ovf`.
- `tgl`  out  N_CH  registered toggle output, one per channel.
- `busy`  out  N_CH  channel has an outstanding transition or a nonzero pending count.
- `pending`  out  N_CH*CNT_W  per-channel pending count; channel i occupies bits [i*CNT_W +: CNT_W].
- `ovf`  out  N_CH  sticky flag: a pulse was dropped.

## Operation
Each channel operates independently. Per-channel state is `tgl_q`, `cnt` and `ovf_q`.

Handshake mode (ACK_EN=1):
- `outstanding` = `tgl_q != ack_tgl`.
- `req` = `pulse | (cnt != 0)`.
- Launch condition: `!outstanding & req`. On launch, `tgl_q` flips.
- Counter update, with `p` = pulse and `l` = launch:
  - p=1, l=1: `cnt` unchanged. If `cnt` is 0, the pulse passes straight through.
  - p=1, l=0: `cnt`+1 if `cnt` < max. If `cnt` == max, the pulse is dropped and `ovf_q` is set.
  - p=0, l=1: `cnt`-1.
  - p=0, l=0: `cnt` unchanged.
- `busy` = `outstanding | (cnt != 0)`. It is combinational from registered state and `ack_tgl`.
- Exactly one transition is in flight per channel at any time. Destination events are never merged, except on overflow.

Plain mode (ACK_EN=0):
- `tgl_q` <= `tgl_q ^ pulse`.
- `cnt` is held at 0. `ovf`, `busy` and `pending` are constant 0.

Overflow flag:
- `ovf_q` is set by a dropped pulse and cleared by `ovf_clr`.
- If a drop and `ovf_clr` occur in the same cycle, set wins.

Reset:
- `tgl`=0, all `pending`=0, `ovf`=0 on the first posedge with `rst_n`=0.
- Pulses during reset are discarded.
- Reset mid-operation discards pending counts. The destination side must be reset concurrently so that `ack_tgl` returns to 0; otherwise `outstanding` reads 1 after reset until `ack_tgl` matches.

## Timing
- `tgl` changes at the posedge where the launching pulse is sampled, so it is visible one cycle after `pulse`. This latency is the same in both modes.
- Back-to-back launches in handshake mode are gated by the ack round-trip. The minimum spacing between `tgl` transitions is the cycle after `ack_tgl` matches `tgl`.
- `pending` and `ovf` are registered and update at the same edge as `tgl`.
- `busy` follows `ack_tgl` combinationally. It drops in the same cycle the matching ack arrives if `cnt` is 0.
- No combinational path exists from `pulse` to any output.

## Test plan
1. Reset, then isolated pulses with an immediate loop-back ack (ACK_EN=1, N_CH=1). Single-cycle pulses at cycles 5 and 20, with `ack_tgl` = `tgl` delayed 3 cycles:
   - `tgl` toggles at cycles 6 and 21.
   - `pending` stays 0.
   - `busy` is high for 3 cycles after each toggle.
2. Burst queuing. Pulse held high for 5 cycles, ack delay 4:
   - The first pulse launches immediately.
   - `pending` peaks at 4.
   - Four further `tgl` transitions occur, each spaced by the ack latency.
   - `pending` returns to 0 and the total toggle count is 5.
3. Overflow. CNT_W=2 with ack held mismatched:
   - 5 pulses give 1 launch and `pending`=3.
   - The 5th pulse sets `ovf`.
   - `ovf_clr` together with a 6th pulse in the same cycle leaves `ovf`=1.
   - `ovf_clr` alone clears it.
4. Simultaneous launch. `pending`=1, `ack_tgl` matches and a pulse arrives in the same cycle:
   - `tgl` flips once.
   - `pending` stays 1.
   - Next cycle: outstanding, no further flip.
5. Plain mode (ACK_EN=0, N_CH=4). Pulse pattern 4'b1010, then 4'b1111 on consecutive cycles:
   - `tgl` = 4'b1010, then 4'b0101.
   - `ack_tgl` toggling has no effect.
   - `busy` and `ovf` stay 0.
6. Reset mid-operation. Assert `rst_n`=0 for 1 cycle with `pending`=2 and `ovf`=1, and reset `ack_tgl` to 0:
   - `tgl`=0, `pending`=0, `ovf`=0.
   - A pulse sampled during reset produces no toggle.
